// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32-step multiply/divide unit that owns the HI/LO
// registers. Signed operands are reduced to magnitudes, processed by an
// unsigned shift-add or restoring-divide datapath, then sign-corrected.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; MTHI/MTLO writes accepted; div-by-zero trap
//   RUN   | one datapath iteration per cycle, counter 0..31
//   FIX   | sign-correct results, write HI/LO, pulse done
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic             is_div;     // latched op[1]
    logic             sign_q;     // product sign (multiply) or quotient sign
    logic             sign_r;     // remainder sign, divide only
    logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] reg_hi;     // accumulator / partial remainder
    logic [WIDTH-1:0] reg_lo;     // multiplier / dividend-then-quotient
    logic             done_next;
    logic             dbz_next;

    // Request decode and operand magnitudes (only signed ops take |x|).
    logic             signed_in;
    logic             b_zero;
    logic             dbz_req;
    logic             accept;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign signed_in = ~op[0];
    assign b_zero    = (b == '0);
    assign dbz_req   = (state == IDLE) && start && op[1] && b_zero;
    assign accept    = (state == IDLE) && start && !(op[1] && b_zero);
    assign abs_a     = (signed_in && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_in && b[WIDTH-1]) ? -b : b;

    // Multiply step: conditional add into the accumulator, then shift the
    // 64-bit {acc, multiplier} pair right by one with the carry shifted in.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    assign mul_sum     = {1'b0, reg_hi} + (reg_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], reg_lo[WIDTH-1:1]};

    // Divide step: the shifted partial remainder is 33 bits. Its top bit is
    // kept separately so the trial subtract only needs the low 32 bits plus
    // a borrow; a set top bit always means the divisor fits.
    logic             rem_top;
    logic [WIDTH-1:0] rem_low;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    assign rem_top     = reg_hi[WIDTH-1];
    assign rem_low     = {reg_hi[WIDTH-2:0], reg_lo[WIDTH-1]};
    assign trial       = {1'b0, rem_low} - {1'b0, opnd};
    assign fits        = rem_top | ~trial[WIDTH];
    assign div_hi_next = fits ? trial[WIDTH-1:0] : rem_low;
    assign div_lo_next = {reg_lo[WIDTH-2:0], fits};

    // Final sign correction: 64-bit product, or quotient/remainder separately.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    assign prod     = {reg_hi, reg_lo};
    assign prod_fix = sign_q ? -prod : prod;
    assign quo_fix  = sign_q ? -reg_lo : reg_lo;
    assign rem_fix  = sign_r ? -reg_hi : reg_hi;
    assign hi_fix   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_fix   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and done/div-by-zero pulse decode.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        dbz_next   = 1'b0;
        case (state)
            IDLE: begin
                if (dbz_req) begin
                    done_next = 1'b1;
                    dbz_next  = 1'b1;
                end else if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == '1) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath, counter and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            is_div      <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            opnd        <= '0;
            reg_hi      <= '0;
            reg_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= done_next;
            div_by_zero <= dbz_next;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        count  <= '0;
                        is_div <= op[1];
                        sign_q <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r <= signed_in & op[1] & a[WIDTH-1];
                        reg_hi <= '0;
                        opnd   <= op[1] ? abs_b : abs_a;
                        reg_lo <= op[1] ? abs_a : abs_b;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (is_div) begin
                        reg_hi <= div_hi_next;
                        reg_lo <= div_lo_next;
                    end else begin
                        reg_hi <= mul_hi_next;
                        reg_lo <= mul_lo_next;
                    end
                end
                FIX: begin
                    hi <= hi_fix;
                    lo <= lo_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed HI/LO results, latency,
// busy/done/div_by_zero behaviour, MTHI/MTLO, ignored requests and reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errors  = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the remainder of an operation until done, counting edges from E0.
    // Also checks busy stays high and HI/LO hold their old value meanwhile.
    task automatic wait_done(input string tag, input int cyc0, input logic [31:0] hold_hi);
        int  cyc;
        logic ok;
        cyc = cyc0;
        ok  = 1'b1;
        while (!done && cyc < 40) begin
            if (!busy || hi !== hold_hi) ok = 1'b0;
            tick();
            cyc++;
        end
        chk({tag, " latency"}, cyc, 33);
        chk({tag, " busy/hold during run"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] old_hi;
        old_hi = hi;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(tag, 0, old_hi);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
        chk({tag, " busy after done"}, {31'd0, busy}, 32'd0);
        chk({tag, " dbz on done"}, {31'd0, div_by_zero}, 32'd0);
        tick();
        chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int  c;
        logic seen;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);

        do_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult -2*3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        do_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu 7/2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        do_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        do_op("divu big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1);

        // MTHI/MTLO: both together, then individually.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
        tick();
        chk("mt both hi", hi, 32'hAAAA_5555);
        chk("mt both lo", lo, 32'hAAAA_5555);
        hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        tick();
        lo_we = 1'b0;
        chk("mthi", hi, 32'h1234_5678);
        chk("mtlo", lo, 32'h9ABC_DEF0);

        // Divide by zero: immediate done with flag, no busy, HI/LO untouched.
        op = OP_DIV; a = 32'd5; b = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("dbz busy", {31'd0, busy}, 32'd0);
        chk("dbz done", {31'd0, done}, 32'd1);
        chk("dbz flag", {31'd0, div_by_zero}, 32'd1);
        chk("dbz hi", hi, 32'h1234_5678);
        chk("dbz lo", lo, 32'h9ABC_DEF0);
        tick();
        chk("dbz done clears", {31'd0, done}, 32'd0);
        chk("dbz flag clears", {31'd0, div_by_zero}, 32'd0);

        // Start and MTLO while busy are ignored.
        op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1; lo_we = 1'b1; wdata = 32'h0000_DEAD;
        tick();
        start = 1'b0; lo_we = 1'b0;
        chk("busy mtlo ignored", lo, 32'h9ABC_DEF0);
        wait_done("busy ignore", 5, 32'h1234_5678);
        chk("busy ignore hi", hi, 32'h0);
        chk("busy ignore lo", lo, 32'd12);
        tick();
        chk("busy ignore no restart", {31'd0, busy}, 32'd0);

        // Reset mid-operation discards the multiply.
        op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset hi", hi, 32'h0);
        chk("midreset lo", lo, 32'h0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (c = 0; c < 40; c++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        chk("midreset no done", {31'd0, seen}, 32'd0);
        do_op("multu 6*7", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit with its own control sequencer. It executes the MIPS MULT, MULTU, DIV and DIVU instructions into the architectural HI/LO registers, and it services MTHI/MTLO writes. It sits beside the ALU: the core issues a one-cycle `start`, stalls on `busy`, then reads `hi`/`lo` for MFHI/MFLO. Signed operations convert operands to magnitude form, run an unsigned 32-step shift-add or restoring-divide datapath, then sign-correct the result.

## Interface
- `WIDTH`, 32, operand width. Only 32 is supported; the iteration counter is log2(WIDTH) bits.

- `clk`  in  1  rising-edge clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  WIDTH  rs operand (multiplicand / dividend)
- `b`  in  WIDTH  rt operand (multiplier / divisor)
- `hi_we`  in  1  MTHI write enable
- `lo_we`  in  1  MTLO write enable
- `wdata`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  high while an operation is in flight; the core stalls on it
- `done`  out  1  one-cycle pulse when HI/LO have been updated or a divide-by-zero has completed
- `div_by_zero`  out  1  valid with `done`; 1 if the divide had `b`==0
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX.
- **IDLE, `start`=1, `b`≠0 or multiply:**
  - Latch `op`.
  - Latch |a| and |b|. The absolute value is taken for signed ops only; 0x80000000 maps to the unsigned value 2^31.
  - Latch sign flags:
    - multiply: product sign = a[31]^b[31]
    - divide: quotient sign = a[31]^b[31]; remainder sign = a[31]
  - Clear the 5-bit counter; go to RUN.
- **IDLE, `start`=1, divide with `b`==0:** stay in IDLE. Next cycle: `done`=1, `div_by_zero`=1, HI/LO unchanged.
- **RUN:** one iteration per cycle; exactly 32 cycles; counter 0..31. When counter==31, go to FIX.
  - Multiply: 64-bit {acc, multiplier} shift-add, LSB-first.
  - Divide: restoring, MSB-first, 33-bit trial subtract of the divisor from the partial remainder.
- **FIX:**
  - Negate results whose sign flag is set (two's complement):
    - 64-bit product
    - quotient and remainder independently
  - Write HI/LO. Multiply: HI = product[63:32], LO = product[31:0]. Divide: LO = quotient, HI = remainder.
  - Go to IDLE; pulse `done`.
- **Overflow case:** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the magnitude path; no special case is needed.
- **MTHI/MTLO:** honoured in IDLE only, written at the clock edge; ignored while `busy`.
  - `hi_we` and `lo_we` together write both registers with `wdata`.
  - MTHI/MTLO in the same cycle as an accepted `start` is performed; the result later overwrites it.
- **`start` while `busy`:** ignored; no queueing.
- **`reset`:** overrides everything, including mid-operation.
  - state=IDLE, counter=0
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0
  - The in-flight operation is discarded.

## Timing
- Edge E0 samples `start`. `busy` is 1 from after E0 until after E33.
- RUN occupies edges E1..E32. FIX is evaluated at E33, where HI/LO update.
- After E33: `done`=1 for exactly one cycle and `busy`=0. A new `start` may be presented in that same cycle.
- Latency from start to result: 33 cycles for every multiply and every nonzero divide, independent of operand values.
- Divide-by-zero: `busy` never rises; `done`/`div_by_zero` are high in the cycle after E0.
- `div_by_zero`: 0 whenever `done`=0, and 0 on `done` for multiplies and valid divides.
- `hi`/`lo` are registered outputs and hold their value during RUN, so MFHI issued early reads the old value.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `busy` for 33 cycles; `done` pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=-2 (0xFFFFFFFE), b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. Then MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 and MTLO 0x9ABCDEF0, then DIV a=5, b=0 -> `done`=1 and `div_by_zero`=1 one cycle later; `busy` stays 0; HI/LO unchanged.
- Start MULTU 3×4. At cycle 5: assert `start` with DIVU, and `lo_we` with wdata=0xDEAD -> both ignored; result HI=0, LO=12 at cycle 33.
- Start MULT 6×7. Assert `reset` at cycle 10 -> next cycle hi=lo=0 and `busy`=0; no `done`. A fresh MULTU 6×7 then yields LO=42 after 33 cycles.
